// File: rtl/sort_stream_collector_if.sv
// ----------------------------------------------------------------------------
// sort_stream_if
//   Bundles the serial sorter stream, the flush control and the block
//   valid/ready handshake of sort_stream_collector.
//   Signals:
//     SortIn      signed element from the sorter
//     InValid     SortIn valid this cycle
//     Flush       discard the partially collected block
//     BlkOut      packed block, element 0 in the LSBs
//     BlkValid    BlkOut holds an undelivered block
//     BlkReady    consumer accepts BlkOut this cycle
//     BlkOrderErr block in BlkOut contains an order violation
//     OrderErr    one-cycle pulse, last accepted element broke order
//     Overflow    sticky, a completed block was dropped
//     BlkCnt      delivered block count (wraps)
//   Modports:
//     master  stream source / block consumer side
//     slave   the collector itself
// ----------------------------------------------------------------------------
interface sort_stream_if #(
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = 4
);
    logic [DATA_W-1:0]         SortIn;
    logic                      InValid;
    logic                      Flush;
    logic [BLK_LEN*DATA_W-1:0] BlkOut;
    logic                      BlkValid;
    logic                      BlkReady;
    logic                      BlkOrderErr;
    logic                      OrderErr;
    logic                      Overflow;
    logic [15:0]               BlkCnt;

    modport master (
        output SortIn, InValid, Flush, BlkReady,
        input  BlkOut, BlkValid, BlkOrderErr, OrderErr, Overflow, BlkCnt
    );

    modport slave (
        input  SortIn, InValid, Flush, BlkReady,
        output BlkOut, BlkValid, BlkOrderErr, OrderErr, Overflow, BlkCnt
    );
endinterface

// File: rtl/sort_stream_collector.sv
// ----------------------------------------------------------------------------
// sort_stream_collector
//   Receive end of the merge-sort output stream. Collects BLK_LEN serial
//   elements into one parallel block, checks that each block is ordered
//   (non-decreasing, or non-increasing when DESCENDING=1) and hands the block
//   to a consumer through a single-entry valid/ready output register.
//   Ports:
//     clk   clock, all state updates on the rising edge
//     rst   synchronous active-high reset
//     bus   sort_stream_if.slave (stream in, flush, block handshake, status)
// ----------------------------------------------------------------------------
module sort_stream_collector #(
    parameter int DATA_W     = 8,
    parameter int BLK_LEN    = 4,
    parameter int DESCENDING = 0
) (
    input  logic         clk,
    input  logic         rst,
    sort_stream_if.slave bus
);
    localparam int IDX_W = (BLK_LEN > 2) ? $clog2(BLK_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

    // Collection state
    logic [IDX_W-1:0]         idx_q;
    logic [DATA_W-1:0]        fill_q [BLK_LEN];
    logic signed [DATA_W-1:0] prev_q;
    logic                     blk_err_q;

    // Output register and status
    logic [BLK_LEN*DATA_W-1:0] blk_out_q;
    logic                      blk_valid_q;
    logic                      blk_order_err_q;
    logic                      order_err_q;
    logic                      overflow_q;
    logic [15:0]               blk_cnt_q;

    // Combinational decode
    logic signed [DATA_W-1:0]  sort_in_s;
    logic                      accept_d;
    logic                      viol_d;
    logic                      complete_d;
    logic                      drain_d;
    logic                      load_d;
    logic [BLK_LEN*DATA_W-1:0] blk_next_d;

    assign sort_in_s = bus.SortIn;

    // Flush beats InValid: the element on a flush cycle is simply dropped.
    assign accept_d = bus.InValid && !bus.Flush;

    // The first element of a block has nothing to compare against, so order
    // is never checked across block boundaries.
    assign viol_d = (idx_q != '0) &&
                    ((DESCENDING != 0) ? (sort_in_s > prev_q) : (sort_in_s < prev_q));

    assign complete_d = accept_d && (idx_q == LAST_IDX);
    assign drain_d    = blk_valid_q && bus.BlkReady;
    // A completed block may enter the output register when it is empty or
    // is being handed off on this very edge; otherwise it is dropped.
    assign load_d     = complete_d && (!blk_valid_q || bus.BlkReady);

    // The final element bypasses the fill buffer so the block can load on
    // the same edge that accepts it.
    generate
        for (genvar gi = 0; gi < BLK_LEN; gi++) begin : g_pack
            if (gi == BLK_LEN - 1) begin : g_last
                assign blk_next_d[gi*DATA_W +: DATA_W] = bus.SortIn;
            end else begin : g_fill
                assign blk_next_d[gi*DATA_W +: DATA_W] = fill_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q           <= '0;
            prev_q          <= '0;
            blk_err_q       <= 1'b0;
            for (int i = 0; i < BLK_LEN; i++) begin
                fill_q[i] <= '0;
            end
            blk_out_q       <= '0;
            blk_valid_q     <= 1'b0;
            blk_order_err_q <= 1'b0;
            order_err_q     <= 1'b0;
            overflow_q      <= 1'b0;
            blk_cnt_q       <= '0;
        end else begin
            order_err_q <= accept_d && viol_d;

            if (bus.Flush) begin
                idx_q     <= '0;
                blk_err_q <= 1'b0;
            end else if (bus.InValid) begin
                fill_q[idx_q] <= bus.SortIn;
                prev_q        <= sort_in_s;
                if (idx_q == LAST_IDX) begin
                    idx_q     <= '0;
                    blk_err_q <= 1'b0;
                end else begin
                    idx_q     <= idx_q + IDX_W'(1);
                    blk_err_q <= blk_err_q | viol_d;
                end
            end

            if (load_d) begin
                blk_out_q       <= blk_next_d;
                blk_order_err_q <= blk_err_q | viol_d;
                blk_valid_q     <= 1'b1;
            end else if (drain_d) begin
                blk_valid_q     <= 1'b0;
            end

            if (complete_d && !load_d) begin
                overflow_q <= 1'b1;
            end

            if (drain_d) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    assign bus.BlkOut      = blk_out_q;
    assign bus.BlkValid    = blk_valid_q;
    assign bus.BlkOrderErr = blk_order_err_q;
    assign bus.OrderErr    = order_err_q;
    assign bus.Overflow    = overflow_q;
    assign bus.BlkCnt      = blk_cnt_q;
endmodule

// File: tb/tb_sort_stream_collector.sv
module tb_sort_stream_collector;
    localparam int DW = 8;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_stream_if #(.DATA_W(DW), .BLK_LEN(BL)) bus ();

    sort_stream_collector #(
        .DATA_W    (DW),
        .BLK_LEN   (BL),
        .DESCENDING(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [7:0] b0, b1, b2, b3;
        b0 = e0[7:0];
        b1 = e1[7:0];
        b2 = e2[7:0];
        b3 = e3[7:0];
        return {b3, b2, b1, b0};
    endfunction

    // Scoreboard: a handshake seen mid-cycle is delivered at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.BlkValid && bus.BlkReady) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got block %h, expected no block", bus.BlkOut);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (bus.BlkOut !== e.data)
                    $display("FAIL sb_data: got %h want %h", bus.BlkOut, e.data);
                else
                    passes++;
                checks++;
                if (bus.BlkOrderErr !== e.err)
                    $display("FAIL sb_err: got %0b want %0b", bus.BlkOrderErr, e.err);
                else
                    passes++;
                $display("block delivered data=%h err=%0b (expected %h/%0b)",
                         bus.BlkOut, bus.BlkOrderErr, e.data, e.err);
            end
        end
    end

    task automatic send(input int v, output logic oerr);
        bus.SortIn  = v[7:0];
        bus.InValid = 1'b1;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        oerr = bus.OrderErr;
    endtask

    task automatic deliver();
        bus.BlkReady = 1'b1;
        @(posedge clk);
        #1;
        bus.BlkReady = 1'b0;
    endtask

    task automatic test_reset();
        bus.SortIn = '0; bus.InValid = 1'b0; bus.Flush = 1'b0; bus.BlkReady = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.BlkValid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", bus.BlkValid); else passes++;
        checks++; if (bus.BlkOut !== 32'h0) $display("FAIL rst_out: got %h want 0", bus.BlkOut); else passes++;
        checks++; if (bus.BlkCnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", bus.BlkCnt); else passes++;
        checks++; if (bus.Overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", bus.Overflow); else passes++;
        checks++; if (bus.OrderErr !== 1'b0) $display("FAIL rst_oerr: got %0b want 0", bus.OrderErr); else passes++;
        // Ready without a valid block must not count anything.
        deliver();
        checks++; if (bus.BlkCnt !== 16'd0) $display("FAIL idle_ready_cnt: got %0d want 0", bus.BlkCnt); else passes++;
        $display("reset test done");
    endtask

    task automatic test_ascending();
        logic e;
        int   vals[4] = '{-5, -1, 3, 7};
        sb_q.push_back('{data: pack4(-5, -1, 3, 7), err: 1'b0});
        for (int i = 0; i < 4; i++) begin
            send(vals[i], e);
            checks++; if (e !== 1'b0) $display("FAIL asc_oerr%0d: got %0b want 0", i, e); else passes++;
            if (i == 2) begin
                checks++; if (bus.BlkValid !== 1'b0) $display("FAIL asc_early_valid: got %0b want 0", bus.BlkValid); else passes++;
            end
        end
        checks++; if (bus.BlkValid !== 1'b1) $display("FAIL asc_latency: got %0b want 1", bus.BlkValid); else passes++;
        deliver();
        checks++; if (bus.BlkCnt !== 16'd1) $display("FAIL asc_cnt: got %0d want 1", bus.BlkCnt); else passes++;
        checks++; if (bus.BlkValid !== 1'b0) $display("FAIL asc_valid_fall: got %0b want 0", bus.BlkValid); else passes++;
        $display("ascending block sent");
    endtask

    task automatic test_order_err();
        logic e;
        int   vals[4] = '{2, 9, 4, 10};
        logic want[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        sb_q.push_back('{data: pack4(2, 9, 4, 10), err: 1'b1});
        for (int i = 0; i < 4; i++) begin
            send(vals[i], e);
            checks++; if (e !== want[i]) $display("FAIL oerr_pulse%0d: got %0b want %0b", i, e, want[i]); else passes++;
        end
        deliver();
        checks++; if (bus.BlkCnt !== 16'd2) $display("FAIL oerr_cnt: got %0d want 2", bus.BlkCnt); else passes++;
        $display("order-error block sent");
    endtask

    task automatic test_back_to_back();
        logic e;
        bus.BlkReady = 1'b0;
        sb_q.push_back('{data: pack4(1, 2, 3, 4), err: 1'b0});
        for (int i = 1; i <= 4; i++) send(i, e);
        sb_q.push_back('{data: pack4(5, 6, 7, 8), err: 1'b0});
        for (int i = 5; i <= 7; i++) send(i, e);
        bus.BlkReady = 1'b1;
        send(8, e);
        bus.BlkReady = 1'b0;
        checks++; if (bus.BlkValid !== 1'b1) $display("FAIL b2b_valid: got %0b want 1", bus.BlkValid); else passes++;
        checks++; if (bus.BlkOut !== pack4(5, 6, 7, 8)) $display("FAIL b2b_out: got %h want %h", bus.BlkOut, pack4(5, 6, 7, 8)); else passes++;
        checks++; if (bus.Overflow !== 1'b0) $display("FAIL b2b_ovf: got %0b want 0", bus.Overflow); else passes++;
        checks++; if (bus.BlkCnt !== 16'd3) $display("FAIL b2b_cnt: got %0d want 3", bus.BlkCnt); else passes++;
        deliver();
        checks++; if (bus.BlkCnt !== 16'd4) $display("FAIL b2b_cnt2: got %0d want 4", bus.BlkCnt); else passes++;
        $display("back-to-back blocks sent");
    endtask

    task automatic test_overflow();
        logic e;
        int   a[4] = '{-3, -3, 0, 0};
        int   b[4] = '{9, 8, 7, 6};
        sb_q.push_back('{data: pack4(-3, -3, 0, 0), err: 1'b0});
        for (int i = 0; i < 4; i++) send(a[i], e);
        for (int i = 0; i < 4; i++) send(b[i], e);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.BlkOut !== pack4(-3, -3, 0, 0)) $display("FAIL ovf_hold: got %h want %h", bus.BlkOut, pack4(-3, -3, 0, 0)); else passes++;
        checks++; if (bus.BlkOrderErr !== 1'b0) $display("FAIL ovf_blkerr: got %0b want 0", bus.BlkOrderErr); else passes++;
        checks++; if (bus.Overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", bus.Overflow); else passes++;
        checks++; if (bus.BlkCnt !== 16'd4) $display("FAIL ovf_cnt: got %0d want 4", bus.BlkCnt); else passes++;
        deliver();
        checks++; if (bus.Overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", bus.Overflow); else passes++;
        checks++; if (bus.BlkValid !== 1'b0) $display("FAIL ovf_drop_valid: got %0b want 0", bus.BlkValid); else passes++;
        $display("overflow scenario done");
    endtask

    task automatic test_flush();
        logic e;
        send(1, e);
        send(2, e);
        bus.Flush = 1'b1;
        send(-8, e);
        bus.Flush = 1'b0;
        checks++; if (e !== 1'b0) $display("FAIL flush_oerr: got %0b want 0", e); else passes++;
        sb_q.push_back('{data: pack4(3, 4, 5, 6), err: 1'b0});
        for (int i = 3; i <= 6; i++) begin
            send(i, e);
            checks++; if (e !== 1'b0) $display("FAIL flush_post_oerr%0d: got %0b want 0", i, e); else passes++;
        end
        checks++; if (bus.BlkValid !== 1'b1) $display("FAIL flush_valid: got %0b want 1", bus.BlkValid); else passes++;
        deliver();
        checks++; if (bus.BlkCnt !== 16'd6) $display("FAIL flush_cnt: got %0d want 6", bus.BlkCnt); else passes++;
        $display("flush scenario done");
    endtask

    task automatic test_rst_mid();
        logic e;
        for (int i = 11; i <= 14; i++) send(i, e);
        send(50, e);
        send(60, e);
        send(70, e);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.BlkValid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus.BlkValid); else passes++;
        checks++; if (bus.BlkCnt !== 16'd0) $display("FAIL rstmid_cnt: got %0d want 0", bus.BlkCnt); else passes++;
        checks++; if (bus.Overflow !== 1'b0) $display("FAIL rstmid_ovf: got %0b want 0", bus.Overflow); else passes++;
        sb_q.push_back('{data: pack4(10, 20, 30, 40), err: 1'b0});
        for (int i = 1; i <= 4; i++) send(i * 10, e);
        checks++; if (bus.BlkValid !== 1'b1) $display("FAIL rstmid_new_valid: got %0b want 1", bus.BlkValid); else passes++;
        deliver();
        checks++; if (bus.BlkCnt !== 16'd1) $display("FAIL rstmid_new_cnt: got %0d want 1", bus.BlkCnt); else passes++;
        $display("mid-block reset scenario done");
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_order_err();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_rst_mid();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0)
            $display("FAIL sb_leftover: got %0d pending blocks want 0", sb_q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
